// File: rtl/sala_req_responder.sv
// Room-side endpoint of the menu request protocol: validates a 2-byte request
// from uart_rx and answers with a 2-byte sensor response through uart_tx.
module sala_req_responder #(
  parameter int unsigned CLK_FREQ       = 25_000_000,
  parameter logic [1:0]  ROOM_ID        = 2'b01,
  parameter int unsigned TIMEOUT_CYCLES = CLK_FREQ / 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic [7:0] temp_value,
  input  logic [7:0] hum_value,
  input  logic       tx_done_pulse,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       frame_err,
  output logic       rx_overrun,
  output logic       busy
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT_B2  = 3'd1;
  localparam logic [2:0] ST_CHECK    = 3'd2;
  localparam logic [2:0] ST_SEND_HDR = 3'd3;
  localparam logic [2:0] ST_WAIT_HDR = 3'd4;
  localparam logic [2:0] ST_SEND_DAT = 3'd5;
  localparam logic [2:0] ST_WAIT_DAT = 3'd6;

  localparam logic [1:0] SENS_PING = 2'b00;
  localparam logic [1:0] SENS_TEMP = 2'b01;
  localparam logic [1:0] SENS_HUM  = 2'b10;
  localparam logic [1:0] SENS_BAD  = 2'b11;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       b1_q, b1_d;
  logic [7:0]       b2_q, b2_d;
  logic [7:0]       data_q, data_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             frame_err_q, frame_err_d;
  logic             rx_overrun_q, rx_overrun_d;
  logic             busy_q, busy_d;

  logic [1:0] req_sensor;
  logic [1:0] req_sala;
  logic       req_malformed;
  logic [7:0] sensor_sel;

  assign req_sensor    = b1_q[3:2];
  assign req_sala      = b1_q[1:0];
  assign req_malformed = (b1_q[7:4] != 4'd0) || (b2_q != 8'd0) || (req_sensor == SENS_BAD);

  // Reading selected by the request; a ping answers with zero.
  always_comb begin
    sensor_sel = 8'h00;
    case (req_sensor)
      SENS_TEMP: sensor_sel = temp_value;
      SENS_HUM:  sensor_sel = hum_value;
      default:   sensor_sel = 8'h00;
    endcase
  end

  // Next-state and registered-output logic; tx_* are set on entry to the SEND states.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    b1_d         = b1_q;
    b2_d         = b2_q;
    data_d       = data_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    frame_err_d  = 1'b0;
    rx_overrun_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          b1_d    = rx_data;
          cnt_d   = '0;
          state_d = ST_WAIT_B2;
        end
      end
      ST_WAIT_B2: begin
        if (rx_valid) begin
          b2_d    = rx_data;
          state_d = ST_CHECK;
        end else if (cnt_q == CNT_LAST) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CHECK: begin
        if (req_malformed) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (req_sala != ROOM_ID) begin
          state_d = ST_IDLE;
        end else begin
          data_d     = sensor_sel;
          tx_start_d = 1'b1;
          tx_data_d  = {4'b1000, req_sensor, req_sala};
          state_d    = ST_SEND_HDR;
        end
      end
      ST_SEND_HDR: state_d = ST_WAIT_HDR;
      ST_WAIT_HDR: begin
        if (tx_done_pulse) begin
          tx_start_d = 1'b1;
          tx_data_d  = data_q;
          state_d    = ST_SEND_DAT;
        end
      end
      ST_SEND_DAT: state_d = ST_WAIT_DAT;
      ST_WAIT_DAT: begin
        if (tx_done_pulse) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Bytes arriving while a request is being checked or answered are dropped.
    if (rx_valid && (state_q != ST_IDLE) && (state_q != ST_WAIT_B2)) begin
      rx_overrun_d = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      b1_q         <= 8'h00;
      b2_q         <= 8'h00;
      data_q       <= 8'h00;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      frame_err_q  <= 1'b0;
      rx_overrun_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      b1_q         <= b1_d;
      b2_q         <= b2_d;
      data_q       <= data_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      frame_err_q  <= frame_err_d;
      rx_overrun_q <= rx_overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign frame_err  = frame_err_q;
  assign rx_overrun = rx_overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sala_req_responder.sv
// Self-checking bench for sala_req_responder: directed protocol cases followed by
// randomized requests checked against a frame-level reference model.
module tb_sala_req_responder;

  localparam logic [1:0]  ROOM = 2'b01;
  localparam int unsigned TMO  = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] temp_value;
  logic [7:0] hum_value;
  logic       tx_done_pulse;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       frame_err;
  logic       rx_overrun;
  logic       busy;

  int n_chk = 0;
  int n_bad = 0;
  int exp_tx = 0, exp_err = 0, exp_ovr = 0;
  int seen_tx = 0, seen_err = 0, seen_ovr = 0;

  sala_req_responder #(
    .CLK_FREQ      (25_000_000),
    .ROOM_ID       (ROOM),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .temp_value   (temp_value),
    .hum_value    (hum_value),
    .tx_done_pulse(tx_done_pulse),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .frame_err    (frame_err),
    .rx_overrun   (rx_overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Pulse tallies over the whole run, compared against the model at the end.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_start)   seen_tx++;
      if (frame_err)  seen_err++;
      if (rx_overrun) seen_ovr++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: 0 = answer, 1 = malformed, 2 = addressed to another room.
  function automatic int classify(input logic [7:0] b1, input logic [7:0] b2);
    logic [1:0] sensor;
    logic [1:0] sala;
    sensor = b1[3:2];
    sala   = b1[1:0];
    if ((b1 >= 8'h10) || (b2 != 8'h00) || (sensor == 2'd3)) return 1;
    if (sala != ROOM) return 2;
    return 0;
  endfunction

  function automatic logic [7:0] resp_data(input logic [7:0] b1, input logic [7:0] t,
                                           input logic [7:0] h);
    logic [1:0] sensor;
    sensor = b1[3:2];
    if (sensor == 2'd1) return t;
    if (sensor == 2'd2) return h;
    return 8'h00;
  endfunction

  // Must be called at a negedge; the byte is sampled on the following posedge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_frame(input logic [7:0] b1, input logic [7:0] b2, input int gap,
                          input int d1, input int d2, input bit ovr, input bit rst_dat);
    int         kind;
    logic [7:0] hdr;
    logic [7:0] dat;
    kind = classify(b1, b2);
    hdr  = 8'h80 + (b1 & 8'h0F);
    dat  = resp_data(b1, temp_value, hum_value);
    send_byte(b1);
    repeat (gap) @(negedge clk);
    send_byte(b2);
    chk("check_quiet", 32'(tx_start), 32'd0);
    if (kind != 0) begin
      tx_done_pulse = 1'b1;
      @(negedge clk);
      tx_done_pulse = 1'b0;
      chk("err_pulse", 32'(frame_err), 32'(kind == 1));
      chk("no_tx", 32'(tx_start), 32'd0);
      chk("rej_idle", 32'(busy), 32'd0);
      if (kind == 1) exp_err++;
      @(negedge clk);
      chk("err_once", 32'(frame_err), 32'd0);
      return;
    end
    @(negedge clk);
    chk("hdr_start", 32'(tx_start), 32'd1);
    chk("hdr_data", 32'(tx_data), 32'(hdr));
    exp_tx++;
    temp_value = 8'($urandom);
    hum_value  = 8'($urandom);
    @(negedge clk);
    chk("hdr_once", 32'(tx_start), 32'd0);
    if (ovr) begin
      rx_data  = 8'($urandom);
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      chk("ovr_pulse", 32'(rx_overrun), 32'd1);
      exp_ovr++;
    end
    repeat (d1) @(negedge clk);
    chk("hdr_hold", 32'(tx_data), 32'(hdr));
    chk("busy_hdr", 32'(busy), 32'd1);
    tx_done_pulse = 1'b1;
    @(negedge clk);
    tx_done_pulse = 1'b0;
    chk("dat_start", 32'(tx_start), 32'd1);
    chk("dat_data", 32'(tx_data), 32'(dat));
    exp_tx++;
    @(negedge clk);
    if (rst_dat) begin
      rst_n = 1'b0;
      #1;
      chk("rst_tx_start", 32'(tx_start), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_quiet", 32'(tx_start), 32'd0);
      return;
    end
    repeat (d2) @(negedge clk);
    chk("dat_hold", 32'(tx_data), 32'(dat));
    chk("busy_dat", 32'(busy), 32'd1);
    tx_done_pulse = 1'b1;
    @(negedge clk);
    tx_done_pulse = 1'b0;
    chk("done_idle", 32'(busy), 32'd0);
  endtask

  task automatic do_timeout(input logic [7:0] b1);
    int early;
    int idle;
    early = 0;
    idle  = 0;
    send_byte(b1);
    for (int i = 0; i < int'(TMO) - 1; i++) begin
      @(negedge clk);
      if (frame_err) early++;
      if (!busy) idle++;
    end
    chk("tmo_early", 32'(early), 32'd0);
    chk("tmo_busy", 32'(idle), 32'd0);
    @(negedge clk);
    chk("tmo_err", 32'(frame_err), 32'd1);
    chk("tmo_idle", 32'(busy), 32'd0);
    exp_err++;
  endtask

  initial begin
    logic [7:0] b1;
    logic [7:0] b2;
    rst_n         = 1'b0;
    rx_data       = 8'h00;
    rx_valid      = 1'b0;
    temp_value    = 8'h00;
    hum_value     = 8'h00;
    tx_done_pulse = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_rx_overrun", 32'(rx_overrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    temp_value = 8'h1A;
    do_frame(8'h05, 8'h00, 0, 2, 2, 1'b0, 1'b0);
    do_frame(8'h01, 8'h00, 1, 0, 0, 1'b0, 1'b0);
    hum_value = 8'h37;
    do_frame(8'h09, 8'h00, 2, 1, 3, 1'b0, 1'b0);
    do_frame(8'h06, 8'h00, 0, 0, 0, 1'b0, 1'b0);
    do_frame(8'h0D, 8'h00, 0, 0, 0, 1'b0, 1'b0);
    do_frame(8'h05, 8'h11, 0, 0, 0, 1'b0, 1'b0);
    do_timeout(8'h05);
    temp_value = 8'h1A;
    do_frame(8'h05, 8'h00, 0, 1, 1, 1'b0, 1'b0);
    do_frame(8'h05, 8'h00, 3, 2, 1, 1'b1, 1'b0);
    do_frame(8'h09, 8'h00, int'(TMO) - 1, 0, 0, 1'b0, 1'b0);
    do_frame(8'h05, 8'h00, 0, 1, 0, 1'b0, 1'b1);
    temp_value = 8'h42;
    do_frame(8'h05, 8'h00, 0, 1, 1, 1'b0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      temp_value = 8'($urandom);
      hum_value  = 8'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        do_timeout(8'($urandom));
      end else begin
        b1 = 8'($urandom_range(0, 15));
        if ($urandom_range(0, 7) == 0) b1 = b1 | 8'($urandom_range(1, 15) * 16);
        b2 = 8'h00;
        if ($urandom_range(0, 7) == 0) b2 = 8'($urandom_range(1, 255));
        do_frame(b1, b2, $urandom_range(0, TMO - 1), $urandom_range(0, 4),
                 $urandom_range(0, 4), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 15) == 0));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    #1;
    chk("total_tx", 32'(seen_tx), 32'(exp_tx));
    chk("total_err", 32'(seen_err), 32'(exp_err));
    chk("total_ovr", 32'(seen_ovr), 32'(exp_ovr));
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/sala_req_responder.md
Name: sala_req_responder

Overview:
- Room-side endpoint of the menu request protocol. It receives the 2-byte request frame from the node's UART receiver and checks that the frame is well formed and addressed to this room.
- It samples the selected sensor reading and returns a 2-byte response frame through the node's UART transmitter.
- It sits between uart_rx/uart_tx and the room's sensor registers.

Parameters:
- CLK_FREQ, 25_000_000, input clock frequency in Hz.
- ROOM_ID, 2'b01, sala code this node answers to (2'b01 or 2'b10).
- TIMEOUT_CYCLES, CLK_FREQ/100, maximum number of cycles allowed between request byte 1 and byte 2 (10 ms).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- rx_data  input  8  byte from the UART receiver.
- rx_valid  input  1  one-cycle pulse; rx_data is valid in that cycle.
- temp_value  input  8  current temperature reading.
- hum_value  input  8  current humidity reading.
- tx_done_pulse  input  1  one-cycle pulse when the UART transmitter finishes a byte.
- tx_start  output  1  one-cycle pulse requesting transmission of tx_data.
- tx_data  output  8  byte to transmit; held stable from tx_start until tx_done_pulse.
- frame_err  output  1  one-cycle pulse on a malformed or timed-out request.
- rx_overrun  output  1  one-cycle pulse when rx_valid arrives while a response is in progress.
- busy  output  1  high in every state except ST_IDLE.

Behaviour:
- Reset (asynchronous, rst_n low): state ST_IDLE; tx_start=0, tx_data=8'h00, frame_err=0, rx_overrun=0, busy=0; timeout counter=0. Reset asserted mid-frame or mid-response aborts immediately; no further tx_start until a new request arrives.
- Request frame: byte1 = {4'b0000, sensor[1:0], sala[1:0]}; byte2 = 8'h00.
- Response frame: byte1 = {4'b1000, sensor, sala}; byte2 = data.
  - data = temp_value when sensor=01, hum_value when sensor=10, 8'h00 when sensor=00 (room-select ping).
- States:
  - ST_IDLE: on rx_valid, latch byte1 and go to ST_WAIT_B2; clear the counter.
  - ST_WAIT_B2: counter increments each cycle.
    - rx_valid goes to ST_CHECK with byte2 latched.
    - If the counter reaches TIMEOUT_CYCLES-1 with no rx_valid: pulse frame_err, go to ST_IDLE.
    - rx_valid in the same cycle as the timeout: byte accepted; the byte wins.
  - ST_CHECK (one cycle), first matching rule applies:
    - byte1[7:4]!=0, byte2!=0, or sensor=11: pulse frame_err, go to ST_IDLE.
    - sala!=ROOM_ID: go to ST_IDLE silently (frame belongs to another node).
    - Otherwise: sample temp_value/hum_value into the data register this cycle, go to ST_SEND_HDR.
  - ST_SEND_HDR: tx_data=response byte1, tx_start=1 for one cycle, go to ST_WAIT_HDR.
  - ST_WAIT_HDR: hold tx_data; on tx_done_pulse go to ST_SEND_DAT.
  - ST_SEND_DAT: tx_data=data, tx_start=1 for one cycle, go to ST_WAIT_DAT.
  - ST_WAIT_DAT: on tx_done_pulse go to ST_IDLE; tx_data is held until then.
- Latency: byte2 rx_valid sampled at edge k; ST_CHECK during cycle k+1; header tx_start high during cycle k+2. Data tx_start is high in the cycle after header tx_done_pulse.
- rx_valid in ST_CHECK, ST_SEND_*, or ST_WAIT_* is dropped and rx_overrun pulses for one cycle. The current response completes unchanged.
- tx_done_pulse outside ST_WAIT_HDR or ST_WAIT_DAT is ignored.
- Changes to sensor inputs after ST_CHECK do not alter the response in flight.
- No back-to-back responses: at least one ST_IDLE cycle between frames.

Test Plan:
- ROOM_ID=01, temp_value=8'h1A: rx bytes 8'h05, 8'h00 -> header tx_start at k+2 with tx_data=8'h85. After tx_done_pulse, tx_start with tx_data=8'h1A. busy falls after the second tx_done_pulse.
- Ping 8'h01, 8'h00 -> response 8'h81 then 8'h00. Humidity request 8'h09, 8'h00 with hum_value=8'h37 -> 8'h89 then 8'h37.
- Wrong room 8'h06, 8'h00 -> no tx_start, no frame_err, back in ST_IDLE. Malformed 8'h0D, 8'h00 (sensor=11) or 8'h05, 8'h11 -> one frame_err pulse, no tx_start.
- TIMEOUT_CYCLES=16: byte 8'h05 then silence -> frame_err 16 cycles later. Next pair 8'h05, 8'h00 -> normal response.
- Extra rx_valid during ST_WAIT_HDR -> rx_overrun pulse, response bytes unchanged. Change temp_value after ST_CHECK -> data byte keeps the sampled value.
- Assert rst_n low during ST_WAIT_DAT -> tx_start=0, tx_data=8'h00, busy=0 immediately. After release, a new valid request is answered normally.
